// File: rtl/mem_stage.sv
// Memory stage: EX/MEM and MEM/WB registers, req/ack data-memory port with byte lanes and timeout abort.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are rejected instead of issued.
module mem_stage #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALU_OUT_EX,
   input  logic [31:0] REG_DATA2_EX_FINAL,
   input  logic [31:0] PC_Branch_EX,
   input  logic        ZERO_EX,
   input  logic        RegWrite_EX,
   input  logic        MemtoReg_EX,
   input  logic        MemRead_EX,
   input  logic        MemWrite_EX,
   input  logic        Branch_EX,
   input  logic [4:0]  RD_EX,
   input  logic [2:0]  FUNCT3_EX,
   output logic [31:0] ALU_OUT_MEM,
   output logic [4:0]  RD_MEM,
   output logic        RegWrite_MEM,
   output logic        PCSrc_MEM,
   output logic [31:0] PC_Branch_MEM,
   output logic        stall_MEM,
   output logic [31:0] ALU_DATA_WB,
   output logic [31:0] READ_DATA_WB,
   output logic [4:0]  RD_WB,
   output logic        RegWrite_WB,
   output logic        MemtoReg_WB,
   output logic        bus_err,
   output logic        misalign_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack
);
   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [31:0] pc_br;
      logic        zero;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic [4:0]  rd;
      logic [2:0]  funct3;
   } exmem_t;

   typedef enum logic {IDLE, WAIT} state_t;

   exmem_t      ex_q, ex_d;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_op, mis, abort, pending;
   logic [1:0]  off;
   logic [31:0] rshift, load_data;
   logic [NUM_LANES-1:0][VEC_W-1:0] lane_wd;
   logic [NUM_LANES-1:0]            lane_be;

   assign ex_d = '{alu: ALU_OUT_EX, wdata: REG_DATA2_EX_FINAL, pc_br: PC_Branch_EX,
                   zero: ZERO_EX, reg_write: RegWrite_EX, mem_to_reg: MemtoReg_EX,
                   mem_read: MemRead_EX, mem_write: MemWrite_EX, branch: Branch_EX,
                   rd: RD_EX, funct3: FUNCT3_EX};

   always_ff @(posedge clk) begin
      if (reset)           ex_q <= '0;
      else if (!stall_MEM) ex_q <= ex_d;
   end

   assign ALU_OUT_MEM   = ex_q.alu;
   assign RD_MEM        = ex_q.rd;
   assign RegWrite_MEM  = ex_q.reg_write;
   assign PC_Branch_MEM = ex_q.pc_br;
   assign PCSrc_MEM     = ex_q.branch & ex_q.zero;

   assign mem_op = ex_q.mem_read | ex_q.mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
   assign mis = mem_op && ((ex_q.funct3[1:0] == 2'b01 && ex_q.alu[0]) ||
                           (ex_q.funct3[1:0] == 2'b10 && ex_q.alu[1:0] != 2'b00));
`else
   assign mis = 1'b0;
`endif

   // Half accesses use the half-word lane, word accesses always lane 0.
   always_comb begin
      case (ex_q.funct3[1:0])
         2'b00:   off = ex_q.alu[1:0];
         2'b01:   off = {ex_q.alu[1], 1'b0};
         default: off = 2'b00;
      endcase
   end

   assign abort   = (state_q == WAIT) && (cnt_q == 8'(TIMEOUT));
   assign pending = mem_op & ~mis & ~abort;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dmem_req  = pending;
      stall_MEM = pending & ~dmem_ack;
      case (state_q)
         IDLE: if (stall_MEM) begin
            state_d = WAIT;
            cnt_d   = 8'd1;
         end
         WAIT: if (!pending || dmem_ack) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   genvar i;
   generate
      for (i = 0; i < NUM_LANES; i++) begin : g_lane
         always_comb begin
            case (ex_q.funct3[1:0])
               2'b00: begin
                  lane_be[i] = (off == 2'(i));
                  lane_wd[i] = ex_q.wdata[VEC_W-1:0];
               end
               2'b01: begin
                  lane_be[i] = (off[1] == (i >= 2));
                  lane_wd[i] = (i % 2 == 1) ? ex_q.wdata[2*VEC_W-1:VEC_W] : ex_q.wdata[VEC_W-1:0];
               end
               default: begin
                  lane_be[i] = 1'b1;
                  lane_wd[i] = ex_q.wdata[VEC_W*i +: VEC_W];
               end
            endcase
         end
      end
   endgenerate

   assign dmem_we    = ex_q.mem_write;
   assign dmem_addr  = {ex_q.alu[31:2], 2'b00};
   assign dmem_be    = lane_be;
   assign dmem_wdata = lane_wd;

   assign rshift = dmem_rdata >> {off, 3'b000};

   always_comb begin
      case (ex_q.funct3)
         3'b000:  load_data = {{24{rshift[7]}},  rshift[7:0]};
         3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
         3'b100:  load_data = {24'h0, rshift[7:0]};
         3'b101:  load_data = {16'h0, rshift[15:0]};
         default: load_data = dmem_rdata;
      endcase
   end

   // Stalled, aborted and rejected cycles retire as bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         ALU_DATA_WB  <= '0;
         READ_DATA_WB <= '0;
         RD_WB        <= '0;
         RegWrite_WB  <= 1'b0;
         MemtoReg_WB  <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         ALU_DATA_WB  <= ex_q.alu;
         READ_DATA_WB <= load_data;
         RD_WB        <= ex_q.rd;
         RegWrite_WB  <= ex_q.reg_write  & ~stall_MEM & ~abort & ~mis;
         MemtoReg_WB  <= ex_q.mem_to_reg & ~stall_MEM & ~abort & ~mis;
         bus_err      <= abort;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset) misalign_err <= 1'b0;
      else       misalign_err <= mis;
   end
`else
   assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, lane handling, wait states, timeout, branch, reset mid-access.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ALU_OUT_EX, REG_DATA2_EX_FINAL, PC_Branch_EX;
   logic        ZERO_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX;
   logic [4:0]  RD_EX;
   logic [2:0]  FUNCT3_EX;
   logic [31:0] ALU_OUT_MEM, PC_Branch_MEM, ALU_DATA_WB, READ_DATA_WB;
   logic [4:0]  RD_MEM, RD_WB;
   logic        RegWrite_MEM, PCSrc_MEM, stall_MEM, RegWrite_WB, MemtoReg_WB;
   logic        bus_err, misalign_err, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   int n_chk  = 0;
   int n_fail = 0;
   int n;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .ALU_OUT_EX(ALU_OUT_EX), .REG_DATA2_EX_FINAL(REG_DATA2_EX_FINAL), .PC_Branch_EX(PC_Branch_EX),
      .ZERO_EX(ZERO_EX), .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
      .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Branch_EX(Branch_EX),
      .RD_EX(RD_EX), .FUNCT3_EX(FUNCT3_EX),
      .ALU_OUT_MEM(ALU_OUT_MEM), .RD_MEM(RD_MEM), .RegWrite_MEM(RegWrite_MEM),
      .PCSrc_MEM(PCSrc_MEM), .PC_Branch_MEM(PC_Branch_MEM), .stall_MEM(stall_MEM),
      .ALU_DATA_WB(ALU_DATA_WB), .READ_DATA_WB(READ_DATA_WB), .RD_WB(RD_WB),
      .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
      .bus_err(bus_err), .misalign_err(misalign_err),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pcb,
                         input logic zero, input logic rw, input logic m2r, input logic mr,
                         input logic mw, input logic br, input logic [4:0] rd, input logic [2:0] f3);
      ALU_OUT_EX = alu; REG_DATA2_EX_FINAL = wd; PC_Branch_EX = pcb;
      ZERO_EX = zero; RegWrite_EX = rw; MemtoReg_EX = m2r;
      MemRead_EX = mr; MemWrite_EX = mw; Branch_EX = br; RD_EX = rd; FUNCT3_EX = f3;
   endtask

   task automatic nop();
      set_ex(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b000);
   endtask

   initial begin
      reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      set_ex(32'h5555, 32'h1, 32'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 3'b010);
      tick(); tick();
      chk("rst_req",    dmem_req, 0);
      chk("rst_stall",  stall_MEM, 0);
      chk("rst_alu",    ALU_OUT_MEM, 0);
      chk("rst_rw_wb",  RegWrite_WB, 0);
      chk("rst_rdata",  READ_DATA_WB, 0);
      chk("rst_buserr", bus_err, 0);
      chk("rst_pcsrc",  PCSrc_MEM, 0);

      // ALU instruction passes straight through
      reset = 1'b0;
      set_ex(32'h1234, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 3'b000);
      tick();
      chk("alu_mem",  ALU_OUT_MEM, 32'h1234);
      chk("rd_mem",   RD_MEM, 5);
      chk("rw_mem",   RegWrite_MEM, 1);
      chk("alu_req",  dmem_req, 0);
      chk("alu_stall", stall_MEM, 0);
      nop();
      tick();
      chk("alu_wb",   ALU_DATA_WB, 32'h1234);
      chk("alu_rw",   RegWrite_WB, 1);
      chk("alu_rdwb", RD_WB, 5);
      chk("alu_m2r",  MemtoReg_WB, 0);

      // LW 0x100, zero-wait
      set_ex(32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 3'b010);
      tick();
      nop(); dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
      chk("lw_req",   dmem_req, 1);
      chk("lw_stall", stall_MEM, 0);
      chk("lw_addr",  dmem_addr, 32'h100);
      chk("lw_be",    dmem_be, 4'b1111);
      chk("lw_we",    dmem_we, 0);
      tick();
      dmem_ack = 1'b0; #1;
      chk("lw_data",  READ_DATA_WB, 32'hDEADBEEF);
      chk("lw_m2r",   MemtoReg_WB, 1);
      chk("lw_rw",    RegWrite_WB, 1);
      chk("lw_rd",    RD_WB, 7);
      chk("lw_idle",  dmem_req, 0);

      // SB 0x203, one wait cycle
      set_ex(32'h203, 32'h000000A5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 3'b000);
      tick();
      nop();
      chk("sb_req",   dmem_req, 1);
      chk("sb_be",    dmem_be, 4'b1000);
      chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
      chk("sb_we",    dmem_we, 1);
      chk("sb_addr",  dmem_addr, 32'h200);
      chk("sb_stall", stall_MEM, 1);
      tick();
      dmem_ack = 1'b1; #1;
      chk("sb_ack_stall", stall_MEM, 0);
      chk("sb_hold_be",   dmem_be, 4'b1000);
      tick();
      dmem_ack = 1'b0; #1;
      chk("sb_done_req",  dmem_req, 0);
      chk("sb_rw_wb",     RegWrite_WB, 0);

      // SH 0x102, zero-wait
      set_ex(32'h102, 32'h1234BEEF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 3'b001);
      tick();
      nop(); dmem_ack = 1'b1; #1;
      chk("sh_be",    dmem_be, 4'b1100);
      chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
      chk("sh_stall", stall_MEM, 0);
      tick();
      dmem_ack = 1'b0; #1;

      // LB 0x1, ack after 3 cycles
      set_ex(32'h1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 3'b000);
      tick();
      nop();
      chk("lb_be", dmem_be, 4'b0010);
      n = 0;
      for (int k = 0; k < 3; k++) begin
         if (stall_MEM) n++;
         if (k > 0) chk("lb_bubble", RegWrite_WB, 0);
         tick();
      end
      chk("lb_stall_cnt", n, 3);
      chk("lb_bubble_last", RegWrite_WB, 0);
      dmem_ack = 1'b1; dmem_rdata = 32'h00008000; #1;
      chk("lb_ack_stall", stall_MEM, 0);
      tick();
      dmem_ack = 1'b0; #1;
      chk("lb_data", READ_DATA_WB, 32'hFFFFFF80);
      chk("lb_rw",   RegWrite_WB, 1);

      // LBU of the same, zero-wait
      set_ex(32'h1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 3'b100);
      tick();
      nop(); dmem_ack = 1'b1; #1;
      tick();
      dmem_ack = 1'b0; #1;
      chk("lbu_data", READ_DATA_WB, 32'h00000080);

      // Timeout: no ack ever
      set_ex(32'h300, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 3'b010);
      tick();
      nop();
      n = 0;
      while (stall_MEM && n < 40) begin
         n++;
         tick();
      end
      chk("to_stall_cnt", n, 15);
      chk("to_req_drop",  dmem_req, 0);
      chk("to_err_early", bus_err, 0);
      tick();
      chk("to_buserr",    bus_err, 1);
      chk("to_bubble",    RegWrite_WB, 0);
      chk("to_resume",    stall_MEM, 0);
      tick();
      chk("to_pulse_end", bus_err, 0);
      chk("to_idle",      dmem_req, 0);

      // Branch taken / not taken
      set_ex(32'h0, 32'h0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 3'b000);
      tick();
      chk("br_pcsrc",  PCSrc_MEM, 1);
      chk("br_target", PC_Branch_MEM, 32'h40);
      set_ex(32'h0, 32'h0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 3'b000);
      tick();
      chk("br_nt_pcsrc", PCSrc_MEM, 0);
      nop();

      // Misaligned SW 0x102
      set_ex(32'h102, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 3'b010);
      tick();
      nop();
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis_req",   dmem_req, 0);
      chk("mis_stall", stall_MEM, 0);
      tick();
      chk("mis_err",   misalign_err, 1);
      tick();
      chk("mis_end",   misalign_err, 0);
`else
      dmem_ack = 1'b1; #1;
      chk("mis_req",   dmem_req, 1);
      chk("mis_addr",  dmem_addr, 32'h100);
      chk("mis_be",    dmem_be, 4'b1111);
      chk("mis_wdata", dmem_wdata, 32'hCAFEF00D);
      tick();
      dmem_ack = 1'b0; #1;
      chk("mis_err",   misalign_err, 0);
`endif

      // Reset asserted mid-WAIT, late ack ignored
      set_ex(32'h400, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 3'b010);
      tick();
      tick();
      chk("rw_wait_stall", stall_MEM, 1);
      reset = 1'b1;
      tick();
      chk("rw_req",   dmem_req, 0);
      chk("rw_stall", stall_MEM, 0);
      chk("rw_alu",   ALU_OUT_MEM, 0);
      chk("rw_rwwb",  RegWrite_WB, 0);
      chk("rw_rdwb",  RD_WB, 0);
      chk("rw_rdata", READ_DATA_WB, 0);
      reset = 1'b0; nop(); dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
      tick();
      chk("rw_late_req", dmem_req, 0);
      chk("rw_late_rw",  RegWrite_WB, 0);
      chk("rw_late_be",  bus_err, 0);
      dmem_ack = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage RISC-V pipeline, directly downstream of the execute stage. Latches the execute-stage results into the EX/MEM register, performs loads and stores over a req/ack data-memory port with byte-lane handling, resolves the branch decision, and drives the MEM/WB register. Stalls the front of the pipeline while a memory access is outstanding, and aborts accesses that exceed a timeout.

## Interface
- TIMEOUT, 15: max cycles `dmem_req` is held without `dmem_ack` before abort (1..255).
- clk  in  1  pipeline clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- ALU_OUT_EX, REG_DATA2_EX_FINAL, PC_Branch_EX  in  32 each  execute-stage results (address/result, store data, branch target).
- ZERO_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX  in  1 each  execute-stage flags/controls.
- RD_EX  in  5  destination register.
- FUNCT3_EX  in  3  access size/sign.
- ALU_OUT_MEM  out  32  EX/MEM ALU result (forwarding source).
- RD_MEM  out  5; RegWrite_MEM  out  1  EX/MEM copies (forwarding unit).
- PCSrc_MEM  out  1  Branch_MEM & ZERO_MEM.
- PC_Branch_MEM  out  32  latched branch target.
- stall_MEM  out  1  hold PC, IF/ID, ID/EX and the EX/MEM capture.
- ALU_DATA_WB, READ_DATA_WB  out  32 each; RD_WB  out  5; RegWrite_WB, MemtoReg_WB  out  1  MEM/WB register.
- bus_err  out  1  one-cycle pulse on timeout abort.
- misalign_err  out  1  one-cycle pulse on misaligned access (macro-dependent).
- dmem_req, dmem_we  out  1; dmem_addr  out  32 (word-aligned, [1:0]=0); dmem_wdata  out  32; dmem_be  out  4.
- dmem_rdata  in  32; dmem_ack  in  1.

## Operation
- EX/MEM register loads all EX inputs on each edge where stall_MEM=0; holds while stall_MEM=1.
- Memory op pending: MemRead_MEM|MemWrite_MEM with access not yet completed, aborted, or rejected.
- FSM states IDLE, WAIT.
  - IDLE: a pending op drives dmem_req=1 combinationally. If dmem_ack=1 in the same cycle, the op completes with no stall. Otherwise stall_MEM=1 and the FSM goes to WAIT with wait counter=1.
  - WAIT: dmem_req=1 and stall_MEM=1 until ack. On ack: complete, stall_MEM=0, return to IDLE.
  - WAIT timeout: when the counter reaches TIMEOUT without ack, abort. bus_err pulses, the instruction retires as a bubble (RegWrite_WB=0), stall releases, and the FSM returns to IDLE.
- dmem_we=MemWrite_MEM. Request outputs are stable for the whole request.
- Store lanes (byte offset o=addr[1:0]):
  - SB (000): be=1<<o, wdata = byte replicated ×4.
  - SH (001): be=0011<<o, wdata = half replicated ×2.
  - SW (010): be=1111.
- Load extraction from dmem_rdata at offset o:
  - LB/LH sign-extend; LBU (100)/LHU (101) zero-extend; LW whole word.
  - Load dmem_be = same lane mask as store.
- MEM/WB loads every cycle. When stall_MEM=1, RegWrite_WB=0 and MemtoReg_WB=0 (bubble); otherwise it takes the EX/MEM fields plus the extracted load data.
- PCSrc_MEM is valid in every cycle, including stalled cycles.
- reset: all EX/MEM and MEM/WB fields, all outputs, FSM (→IDLE) and counter go to 0. This applies mid-access as well: the request is dropped and a late ack is ignored.

## Timing
- Non-memory instruction: 1 cycle EX/MEM → MEM/WB, no stall.
- Zero-wait memory (ack with req): 1 cycle, no stall.
- N-cycle ack: stall_MEM high for N cycles. Data is captured into MEM/WB on the ack edge.
- Timeout: stall_MEM high for exactly TIMEOUT cycles, then bus_err pulses in the cycle after the abort edge.
- Back-to-back memory ops: the next op is captured on the completion edge, and its request starts the following cycle.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issue no request.
  - misalign_err pulses one cycle, the instruction retires as a bubble, and there is no stall.
- Undefined: misaligned accesses go ahead as if addr[1:0]=0 for half/word sizes (SH/LH/LHU use lane offset addr[1]×2). misalign_err is tied 0.

## Test plan
- LW, addr 0x100, ack same cycle, rdata 0xDEADBEEF → no stall; next cycle READ_DATA_WB=0xDEADBEEF, MemtoReg_WB=1.
- SB, addr 0x203, data 0x000000A5 → dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_we=1.
- LB, addr 0x1, rdata 0x00008000, ack after 3 cycles → stall_MEM high 3 cycles with bubbles to WB; then READ_DATA_WB=0xFFFFFF80. LBU of the same gives 0x00000080.
- No ack, TIMEOUT=15 → stall 15 cycles, bus_err single pulse, RegWrite_WB=0, pipeline resumes.
- Branch with ZERO_EX=1, target 0x40 → next cycle PCSrc_MEM=1, PC_Branch_MEM=0x40.
- With MEM_MISALIGN_TRAP_EN, SW to 0x102 → no dmem_req, misalign_err pulse, no stall. Reset asserted mid-WAIT → dmem_req=0 next cycle and all outputs 0.
